// File: rtl/uart_word_loader_pkg.sv
// Shared definitions for the UART word loader: rx FSM states,
// oversampling constants and the baud-tick divider formula.
package uart_word_loader_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    localparam int MID_TICK  = 7;
    localparam int BIT_TICKS = 16;

    function automatic int div_calc(
        input int clk_hz,
        input int baud,
        input int oversample
    );
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_word_loader_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, oversample tick divider
// and rx FSM producing one-cycle byteValid / frameErr pulses.
module uart_rx_core
    import uart_word_loader_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serialIn,
    output logic       byteValid,
    output logic [7:0] rxByte,
    output logic       frameErr
);

    localparam int DIV   = div_calc(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [3:0]       MID      = 4'(MID_TICK);
    localparam logic [3:0]       LAST     = 4'(BIT_TICKS - 1);

    logic             sync1;
    logic             sync2;
    logic             line_prev;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             start_edge;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    rx_state_e        state;

    // Flops reset low so a line already low at release is not a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            line_prev <= 1'b0;
        end else begin
            sync1     <= serialIn;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign start_edge = (state == RX_IDLE) && line_prev && !sync2;
    assign tick       = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (start_edge || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RX_IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rxByte    <= '0;
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (start_edge) begin
                        state    <= RX_START;
                        tick_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (tick_cnt == MID) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= sync2 ? RX_IDLE : RX_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (tick_cnt == LAST) begin
                            tick_cnt <= '0;
                            shift    <= {sync2, shift[7:1]};
                            bit_idx  <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= RX_STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (tick_cnt == LAST) begin
                            tick_cnt <= '0;
                            if (sync2) begin
                                byteValid <= 1'b1;
                                rxByte    <= shift;
                                state     <= RX_IDLE;
                            end else begin
                                frameErr <= 1'b1;
                                state    <= RX_BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                RX_BREAK: begin
                    if (tick) begin
                        if (!sync2) begin
                            tick_cnt <= '0;
                        end else if (tick_cnt == LAST) begin
                            tick_cnt <= '0;
                            state    <= RX_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// UART loader: packs received bytes little-endian into 32-bit words
// and writes them to RAM port 2 at an auto-incrementing address.
module uart_word_loader
    import uart_word_loader_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serialIn,
    input  logic                  setAddr,
    input  logic [ADDR_WIDTH-1:0] startAddr,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] writeAddr,
    output logic [31:0]           writeData,
    output logic [7:0]            lastByte,
    output logic                  err
);

    logic                  byte_valid;
    logic [7:0]            rx_byte;
    logic                  frame_err;
    logic [1:0]            byte_cnt;
    logic [23:0]           word;
    logic [ADDR_WIDTH-1:0] ptr;

    uart_rx_core #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .serialIn  (serialIn),
        .byteValid (byte_valid),
        .rxByte    (rx_byte),
        .frameErr  (frame_err)
    );

    // The core only loads rxByte on a good stop bit, so it is lastByte.
    assign lastByte = rx_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            writeEnable <= 1'b0;
            writeAddr   <= '0;
            writeData   <= '0;
            err         <= 1'b0;
            byte_cnt    <= '0;
            word        <= '0;
            ptr         <= '0;
        end else begin
            writeEnable <= 1'b0;
            if (frame_err) begin
                err <= 1'b1;
            end
            if (setAddr) begin
                ptr      <= startAddr;
                byte_cnt <= '0;
            end else if (byte_valid) begin
                unique case (byte_cnt)
                    2'd0: word[7:0]   <= rx_byte;
                    2'd1: word[15:8]  <= rx_byte;
                    2'd2: word[23:16] <= rx_byte;
                    2'd3: begin
                        writeEnable <= 1'b1;
                        writeData   <= {rx_byte, word};
                        writeAddr   <= ptr;
                        ptr         <= ptr + 1'b1;
                    end
                    default: ;
                endcase
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule
